// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider: per-channel registered divided clock,
// period-start tick strobe, and shadowed configuration applied only at period boundaries.
module multi_clock_divider #(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              sync_start,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic cfg_ok;

  assign cfg_ok = (cfg_div >= DIV_W'(2)) && (int'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div_s;
    logic             en_s;
    logic [DIV_W-1:0] div_a;
    logic             en_a;
    logic [DIV_W-1:0] cnt;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic             hit;
    logic             boundary;
    logic             apply;
    logic [DIV_W-1:0] nxt_div;
    logic             nxt_en;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W:0]   half;

    always_comb begin
      hit      = cfg_wr && cfg_ok && (int'(cfg_ch) == g);
      boundary = !en_a || (cnt == div_a - DIV_W'(1));
      // sync_start forces an early boundary so pending/bypass config lands with the realignment
      apply    = (boundary || sync_start) && (pend_q || hit);
      nxt_div  = hit ? cfg_div : div_s;
      nxt_en   = hit ? cfg_en  : en_s;
      cnt_inc  = cnt + DIV_W'(1);
      half     = ({1'b0, div_a} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_s  <= DIV_W'(2);
        en_s   <= 1'b0;
        div_a  <= DIV_W'(2);
        en_a   <= 1'b0;
        cnt    <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (hit) begin
          div_s <= cfg_div;
          en_s  <= cfg_en;
        end
        if (apply) begin
          div_a  <= nxt_div;
          en_a   <= nxt_en;
          pend_q <= 1'b0;
          cnt    <= '0;
          clk_q  <= nxt_en;
          tick_q <= nxt_en;
        end else begin
          if (hit) begin
            pend_q <= 1'b1;
          end
          if (!en_a) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
          end else if (boundary || sync_start) begin
            cnt    <= '0;
            clk_q  <= 1'b1;
            tick_q <= 1'b1;
          end else begin
            cnt    <= cnt_inc;
            clk_q  <= ({1'b0, cnt_inc} < half);
            tick_q <= 1'b0;
          end
        end
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: directed vector table, hand-written corner sequences and
// randomized traffic checked against a position-based behavioural model.
module tb_multi_clock_divider;

  localparam int NCH = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_en = 1'b0;
  logic          sync_start = 1'b0;
  logic          cfg_err;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int total = 0;
  int bad   = 0;

  multi_clock_divider #(.NUM_CH(NCH), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .sync_start(sync_start), .cfg_err(cfg_err), .clk_out(clk_out),
    .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Model: each channel is a position within its current period; outputs derive from it.
  int m_div[NCH], m_sdiv[NCH], m_pos[NCH];
  bit m_en[NCH], m_sen[NCH], m_pend[NCH];
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = 2; m_sdiv[i] = 2; m_pos[i] = 0;
      m_en[i] = 0; m_sen[i] = 0; m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_edge(input bit wr, input int ch, input int dv, input bit en, input bit sy);
    bit legal, hit, at_end;
    legal = wr && dv >= 2 && ch < NCH;
    m_err = wr && !legal;
    for (int i = 0; i < NCH; i++) begin
      hit    = legal && ch == i;
      at_end = !m_en[i] || m_pos[i] == m_div[i] - 1;
      if ((at_end || sy) && (m_pend[i] || hit)) begin
        m_div[i]  = hit ? dv : m_sdiv[i];
        m_en[i]   = hit ? en : m_sen[i];
        m_pend[i] = 0;
        m_pos[i]  = 0;
      end else begin
        if (hit) m_pend[i] = 1;
        if (m_en[i]) m_pos[i] = (at_end || sy) ? 0 : m_pos[i] + 1;
      end
      if (hit) begin
        m_sdiv[i] = dv;
        m_sen[i]  = en;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_clk();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_en[i] && m_pos[i] < (m_div[i] + 1) / 2;
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_en[i] && m_pos[i] == 0;
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT samples, compare, clear strobes.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(cfg_wr, int'(cfg_ch), int'(cfg_div), cfg_en, sync_start);
    #1;
    check("clk_out", 32'(clk_out), 32'(exp_clk()));
    check("tick",    32'(tick),    32'(exp_tick()));
    check("pending", 32'(pending), 32'(exp_pend()));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    cfg_wr = 0;
    sync_start = 0;
  endtask

  task automatic write(input int ch, input int dv, input bit en);
    cfg_wr = 1; cfg_ch = 2'(ch); cfg_div = DW'(dv); cfg_en = en;
  endtask

  typedef struct {
    bit wr; int ch; int dv; bit en; bit sy;
    logic [NCH-1:0] clk; logic [NCH-1:0] tk; logic [NCH-1:0] pd; bit err;
  } vec_t;

  vec_t tbl[23];
  int   hi_cnt, tk_cnt, r;

  initial begin
    tbl[0]  = '{1, 0, 4, 1, 0, 3'b001, 3'b001, 3'b000, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 0};
    tbl[5]  = '{1, 1, 5, 1, 0, 3'b011, 3'b010, 3'b000, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 0};
    tbl[9]  = '{1, 2, 1, 1, 0, 3'b001, 3'b000, 3'b000, 1};
    tbl[10] = '{1, 3, 6, 1, 0, 3'b010, 3'b010, 3'b000, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 3'b011, 3'b001, 3'b000, 0};
    tbl[13] = '{1, 0, 6, 1, 0, 3'b001, 3'b000, 3'b001, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b001, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 3'b011, 3'b001, 3'b000, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 3'b011, 3'b000, 3'b000, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0};
    tbl[22] = '{0, 0, 0, 0, 0, 3'b011, 3'b001, 3'b000, 0};

    model_reset();
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1;
    for (int i = 0; i < 20; i++) cycle();

    foreach (tbl[i]) begin
      cfg_wr = tbl[i].wr; cfg_ch = 2'(tbl[i].ch); cfg_div = DW'(tbl[i].dv);
      cfg_en = tbl[i].en; sync_start = tbl[i].sy;
      cycle();
      check("tbl_clk",  32'(clk_out), 32'(tbl[i].clk));
      check("tbl_tick", 32'(tick),    32'(tbl[i].tk));
      check("tbl_pend", 32'(pending), 32'(tbl[i].pd));
      check("tbl_err",  32'(cfg_err), 32'(tbl[i].err));
    end

    // ch0 sits in the first high cycle of a div=6 period: disable must let it finish.
    write(0, 6, 0);
    hi_cnt = 0; tk_cnt = 0;
    cycle();
    if (clk_out[0]) hi_cnt++;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (clk_out[0]) hi_cnt++;
      if (tick[0]) tk_cnt++;
    end
    check("dis_high_cycles", 32'(hi_cnt), 32'd2);
    check("dis_no_tick", 32'(tk_cnt), 32'd0);
    check("dis_pend_clear", 32'(pending[0]), 32'd0);

    // Asynchronous reset mid-cycle clears outputs before any edge.
    #2 rst_n = 0;
    #1;
    check("async_rst_clk", 32'(clk_out), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    cycle();
    rst_n = 1;

    write(0, 4, 1);
    cycle();
    cycle(); cycle();
    write(1, 8, 1);
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    sync_start = 1;
    cycle();
    check("sync_ticks", 32'(tick[1:0]), 32'd3);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) cycle();
      check("sync_coincide", 32'(tick[1:0]), 32'd3);
    end

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 9);
        write($urandom_range(0, 3), (r == 9) ? $urandom_range(9, 30) : r,
              $urandom_range(0, 9) < 7);
      end
      if ($urandom_range(0, 39) == 0) sync_start = 1;
      if (n == 400) begin
        #3 rst_n = 0;
        #1 check("rand_async_rst", 32'(clk_out), 32'd0);
        cycle();
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
